// File: rtl/arb_mux_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : arb_mux_pkg
//  Description : Shared constants, lock-state encoding and helpers for the
//                arb_mux arbitrating multiplexer.
//  Revision    : 1.0 - initial release
// ============================================================================
package arb_mux_pkg;

    // Arbitration mode selectors for the MODE parameter
    localparam int MODE_RR    = 0;
    localparam int MODE_FIXED = 1;

    // Packet lock state (only used when packet locking is compiled in)
    typedef enum logic [0:0] {
        ST_OPEN   = 1'b0,
        ST_LOCKED = 1'b1
    } lock_state_t;

    // Modulo-n increment used for the round-robin pointer
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage : arb_mux_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational arbiter. Searches the request vector starting
//                at ptr, wrapping N-1 -> 0, and returns a one-hot grant plus
//                the encoded winner. When lock_en is set only lock_idx may win.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    input  logic                 lock_en,
    input  logic [$clog2(N)-1:0] lock_idx,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] idx
);

    localparam int PW = $clog2(N);

    logic [PW:0]   w_sum;
    logic [PW-1:0] w_cand;

    // Walk candidates from farthest to nearest so the nearest request to ptr
    // is written last and wins; a lock overrides the search entirely.
    always_comb begin
        grant  = '0;
        idx    = '0;
        w_sum  = '0;
        w_cand = '0;
        if (lock_en) begin
            if (req[lock_idx]) begin
                grant[lock_idx] = 1'b1;
                idx             = lock_idx;
            end
        end else begin
            for (int k = N - 1; k >= 0; k--) begin
                w_sum = {1'b0, ptr} + (PW+1)'(k);
                if (w_sum >= (PW+1)'(N)) begin
                    w_sum = w_sum - (PW+1)'(N);
                end
                w_cand = w_sum[PW-1:0];
                if (req[w_cand]) begin
                    grant         = '0;
                    grant[w_cand] = 1'b1;
                    idx           = w_cand;
                end
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/arb_mux.sv
`default_nettype none
// ============================================================================
//  Module      : arb_mux
//  Description : N-channel valid/ready arbitrating multiplexer with a single
//                registered output stage. Round-robin or fixed priority.
//                Optional packet locking is enabled by defining the macro
//                ARB_MUX_LOCK_EN, which adds in_last / out_last.
//  Revision    : 1.0 - initial release
// ============================================================================
module arb_mux
    import arb_mux_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int MODE  = MODE_RR
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [$clog2(N)-1:0] out_sel
`ifdef ARB_MUX_LOCK_EN
    ,
    input  logic [N-1:0]         in_last,
    output logic                 out_last
`endif
);

    localparam int PW = $clog2(N);

    logic [PW-1:0]    r_ptr;
    logic [N-1:0]     w_grant;
    logic [PW-1:0]    w_gidx;
    logic             w_ld;
    logic             w_xfer;
    logic             w_lock_en;
    logic [PW-1:0]    w_lock_idx;
    logic             w_beat_last;
    logic [WIDTH-1:0] w_sel_data;

    // The output register can take a beat when empty or being drained
    assign w_ld     = !out_valid || out_ready;
    assign in_ready = {N{w_ld}} & w_grant;
    assign w_xfer   = |in_ready;

    rr_arbiter #(
        .N        (N)
    ) u_arb (
        .req      (in_valid),
        .ptr      (r_ptr),
        .lock_en  (w_lock_en),
        .lock_idx (w_lock_idx),
        .grant    (w_grant),
        .idx      (w_gidx)
    );

    // One-hot data select of the granted channel
    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < N; i++) begin
            if (w_grant[i]) begin
                w_sel_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

`ifdef ARB_MUX_LOCK_EN
    lock_state_t   r_state;
    logic [PW-1:0] r_lock_idx;

    assign w_lock_en   = (r_state == ST_LOCKED);
    assign w_lock_idx  = r_lock_idx;
    assign w_beat_last = in_last[w_gidx];

    // Packet lock FSM; out_last travels with the beat it belongs to
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_OPEN;
            r_lock_idx <= '0;
            out_last   <= 1'b0;
        end else if (w_xfer) begin
            out_last <= in_last[w_gidx];
            case (r_state)
                ST_OPEN: begin
                    if (!in_last[w_gidx]) begin
                        r_state    <= ST_LOCKED;
                        r_lock_idx <= w_gidx;
                    end
                end
                ST_LOCKED: begin
                    if (in_last[w_gidx]) begin
                        r_state <= ST_OPEN;
                    end
                end
                default: r_state <= ST_OPEN;
            endcase
        end
    end
`else
    // Every beat is its own packet: never locked, always terminating
    assign w_lock_en   = 1'b0;
    assign w_lock_idx  = '0;
    assign w_beat_last = 1'b1;
`endif

    // Output register and round-robin pointer; the pointer only moves on a
    // packet-terminating beat so it stays put while a packet is locked
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            r_ptr     <= '0;
        end else begin
            if (w_xfer) begin
                out_valid <= 1'b1;
                out_data  <= w_sel_data;
                out_sel   <= w_gidx;
                if (MODE == MODE_RR && w_beat_last) begin
                    r_ptr <= PW'(wrap_inc(int'(w_gidx), N));
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule : arb_mux
`default_nettype wire

// File: doc/arb_mux.md
ARB_MUX -- requirements
Module: arb_mux

Interface
REQ-001 Parameter WIDTH, default 32: data width per channel, >=1.
REQ-002 Parameter N, default 4: input channel count, 2..16.
REQ-003 Parameter MODE, default MODE_RR: MODE_RR is round-robin arbitration; MODE_FIXED is fixed priority, lowest index wins.
REQ-004 clk  input  1  sole clock; all state SHALL change on rising edge only.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 in_valid  input  N  per-channel request.
REQ-008 in_ready  output  N  per-channel accept; at most one bit high per cycle.
REQ-009 out_data  output  WIDTH  registered selected data.
REQ-010 out_valid  output  1  out_data holds a beat.
REQ-011 out_ready  input  1  downstream accept.
REQ-012 out_sel  output  $clog2(N)  index of channel that supplied out_data.

Function
REQ-013 Transfer on any port SHALL occur when valid and ready are both high at a rising edge.
REQ-014 Load enable: ld = !out_valid || out_ready; in_ready[g] SHALL equal ld && grant[g], combinational from in_valid, the pointer and ld.
REQ-015 Grant SHALL be one-hot among asserted in_valid, all-zero when no in_valid is high.
REQ-016 MODE_RR: search SHALL start at index ptr and wrap N-1 -> 0; after a transfer from channel g, ptr SHALL become (g+1) mod N.
REQ-017 ptr SHALL hold when no input transfer occurs.
REQ-018 MODE_FIXED: lowest-indexed valid channel wins; ptr unused, held at 0.
REQ-019 Latency one cycle: an input transfer at edge k SHALL present its data on out_data/out_sel with out_valid=1 after edge k.
REQ-020 Full throughput: with out_ready held high, one beat per cycle SHALL pass.
REQ-021 Stall: while out_valid=1 and out_ready=0, out_data/out_sel/out_valid SHALL hold and all in_ready SHALL be 0.
REQ-022 Simultaneous output accept and new input transfer in one cycle SHALL replace the register; out_valid stays 1.
REQ-023 Output accept without input transfer SHALL clear out_valid.
REQ-024 No combinational path from in_valid to out_valid or out_data.

Reset
REQ-025 rst_n low SHALL immediately clear out_valid, out_data=0, out_sel=0, ptr=0 and lock state, without waiting for clk.
REQ-026 Reset asserted mid-transfer SHALL discard the held beat; the first edge after deassertion SHALL arbitrate from ptr=0.

Configuration
REQ-027 Macro ARB_MUX_LOCK_EN: when defined, add in_last (input, N) and out_last (output, 1, registered alongside out_data, reset 0).
REQ-028 With ARB_MUX_LOCK_EN, a two-state machine SHALL run: OPEN (arbitrate normally) -> LOCKED on a transfer with in_last[g]=0; LOCKED grants only the locked channel; LOCKED -> OPEN on a transfer of that channel with in_last=1.
REQ-029 In LOCKED, ptr SHALL NOT advance; it advances per REQ-016 on the terminating beat.
REQ-030 Without the macro, no last ports exist and every beat is arbitrated independently.

Structure
REQ-031 Package arb_mux_pkg SHALL hold MODE_RR/MODE_FIXED constants and the lock-state encoding (ST_OPEN, ST_LOCKED).
REQ-032 Sub-module rr_arbiter (parameter N; inputs req, ptr, lock_en, lock_idx; output one-hot grant and encoded index) SHALL contain all arbitration logic; arb_mux holds the registers and pointer.

Verification (N=4, WIDTH=32, MODE_RR unless stated)
REQ-033 All four valid with data 0xA0..0xA3, out_ready=1 for 8 cycles -> out_sel sequence 0,1,2,3,0,1,2,3; one beat per cycle.
REQ-034 Only ch3 and ch0 valid, ptr=3 -> grants 3 then 0 (wrap), ptr ends at 1.
REQ-035 out_ready=0 for 5 cycles with beat 0xDEADBEEF held -> out_data stable, in_ready=0000 throughout; out_ready=1 -> next beat loads the following cycle.
REQ-036 MODE_FIXED, ch1 and ch2 continuously valid -> ch1 granted every cycle, ch2 starved.
REQ-037 rst_n pulsed low mid-stream asynchronously between edges -> out_valid drops immediately; after release first grant is lowest valid index.
REQ-038 ARB_MUX_LOCK_EN: ch2 sends 3 beats, last on beat 3, while ch0 is valid -> outputs 2,2,2 then 0; out_last=1 only on beat 3.
